freq_div_ctrl: RTL and testbench
================================

// Module: freq_div_ctrl
// PURPOSE
//  Run-time controller for the clock-divider path. Takes divide-ratio updates over a
//  valid/ready handshake and produces a divided clock_out (logic clock, registered).
//  Ratio changes and start/stop happen only on period boundaries, so clk_out never
//  glitches or produces a runt pulse. Sits between the config/CSR logic and divided-clock consumers.
// PARAMETERS
//  CNT_W        8    width of divide ratio and period counter
//  DEFAULT_DIV  64   ratio loaded at reset (must be >= 2 and < 2**CNT_W)
// PORTS
//  clk_in     in   1      single clock; all logic on its rising edge
//  reset      in   1      asynchronous, active-low reset
//  en         in   1      1 = run divider, 0 = stop at end of current period
//  cfg_valid  in   1      new ratio offered on cfg_div
//  cfg_div    in   CNT_W  requested ratio N (legal N >= 2)
//  cfg_ready  out  1      controller can accept a ratio this cycle
//  cfg_err    out  1      1-cycle pulse: illegal ratio (N < 2) accepted and discarded
//  clk_out    out  1      divided clock, period N clk_in cycles, high floor(N/2) cycles
//  tick       out  1      1-cycle pulse coincident with each clk_out rising edge
//  busy       out  1      1 when state != IDLE
// BEHAVIOUR
//  Reset (async, reset=0): state=IDLE, cnt=0, cur_div=DEFAULT_DIV, pend=0,
//   clk_out=0, tick=0, cfg_err=0; outputs go low immediately, not at next edge.
//  cfg_ready = (state != PEND). Handshake completes on a clock edge where
//   cfg_valid & cfg_ready = 1. cfg_div is sampled on that edge.
//  Illegal ratio (cfg_div < 2): handshake completes, cfg_err=1 next cycle,
//   cur_div and state are unchanged.
//  States:
//   IDLE: cnt=0, clk_out=0. Accepted legal cfg sets cur_div=cfg_div on the same edge.
//     en=1 -> RUN: cnt<=0, clk_out<=1, tick<=1. This start uses the ratio written on
//     the same edge, if there is one.
//   RUN: non-wrap edge (cnt != cur_div-1): cnt<=cnt+1,
//     clk_out<=((cnt+1) < (cur_div>>1)), tick<=0.
//     Accepted legal cfg: pend_div<=cfg_div, state becomes PEND.
//   PEND: counts exactly as in RUN; cfg_ready=0.
//   Wrap edge (cnt == cur_div-1) in RUN or PEND:
//     if PEND, cur_div<=pend_div and state leaves PEND;
//     if en=1: cnt<=0, clk_out<=1, tick<=1, state=RUN (the new period uses the new ratio);
//     if en=0: cnt<=0, clk_out<=0, tick<=0, state=IDLE.
//  en is sampled only in IDLE and on wrap edges. Deasserting en mid-period never
//   truncates that period.
//  Output latency: clk_out and tick are registered, with 1 cycle from the deciding edge.
//  Duty: N even -> 50%. N odd -> high (N-1)/2, low (N+1)/2. N=2 -> toggles every cycle.
//  cnt is CNT_W wide and never exceeds cur_div-1. There is no other wrap-around.
//  cfg_valid with cfg_ready=0 is held off. The requester must hold cfg_valid and cfg_div stable.
// TESTING
//  1 Release reset, en=1, no cfg -> tick every 64 cycles, clk_out high 32 / low 32, busy=1.
//  2 In IDLE, cfg_div=5 handshake, then en=1 -> period 5: high 2, low 3. The first
//    tick comes 1 cycle after en is sampled.
//  3 Running at N=4, offer cfg_div=6 mid-period -> cfg_ready=0 until wrap. The current
//    period completes at 4 cycles, then periods are 6 (high 3). cfg_ready returns to 1.
//  4 Offer cfg_div=1 (and 0) -> cfg_err pulses one cycle. Ratio and period are unchanged.
//  5 Running at N=8, drop en at cnt=2 -> remaining cycles complete, then clk_out=0,
//    busy=0 after wrap, and no extra tick.
//  6 Assert reset mid-period while PEND -> clk_out, tick and busy drop at once. After
//    release, en=1 gives period 64 and the pending ratio is discarded.

Source files
------------

// File: rtl/freq_div_ctrl.sv
// Run-time clock-divider controller: ratio updates over valid/ready, glitch-free
// registered clk_out whose ratio and start/stop only change on period boundaries.
module freq_div_ctrl #(
   parameter int CNT_W       = 8,
   parameter int DEFAULT_DIV = 64
) (
   input  logic             clk_in,
   input  logic             reset,
   input  logic             en,
   input  logic             cfg_valid,
   input  logic [CNT_W-1:0] cfg_div,
   output logic             cfg_ready,
   output logic             cfg_err,
   output logic             clk_out,
   output logic             tick,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;

   localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] TWO     = CNT_W'(2);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [CNT_W-1:0] cur_div, cur_div_nxt;
   logic [CNT_W-1:0] pend_div, pend_div_nxt;
   logic [CNT_W-1:0] cnt_inc;
   logic             clk_out_nxt, tick_nxt, cfg_err_nxt;
   logic             accept, legal, wrap;

   assign cfg_ready = (state != PEND);
   assign busy      = (state != IDLE);
   assign accept    = cfg_valid & cfg_ready;
   assign legal     = (cfg_div >= TWO);
   assign wrap      = (state != IDLE) && (cnt == cur_div - ONE);
   assign cnt_inc   = cnt + ONE;

   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         cnt      <= '0;
         cur_div  <= DEF_DIV;
         pend_div <= '0;
         clk_out  <= 1'b0;
         tick     <= 1'b0;
         cfg_err  <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         cur_div  <= cur_div_nxt;
         pend_div <= pend_div_nxt;
         clk_out  <= clk_out_nxt;
         tick     <= tick_nxt;
         cfg_err  <= cfg_err_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      cur_div_nxt  = cur_div;
      pend_div_nxt = pend_div;
      clk_out_nxt  = clk_out;
      tick_nxt     = 1'b0;
      cfg_err_nxt  = accept & ~legal;

      unique case (state)
         IDLE: begin
            cnt_nxt     = '0;
            clk_out_nxt = 1'b0;
            if (accept && legal) cur_div_nxt = cfg_div;
            if (en) begin
               state_nxt   = RUN;
               clk_out_nxt = 1'b1;
               tick_nxt    = 1'b1;
            end
         end
         RUN, PEND: begin
            if (wrap) begin
               // A ratio accepted exactly on a RUN wrap edge is itself on a boundary, so apply it now.
               if (state == PEND)          cur_div_nxt = pend_div;
               else if (accept && legal)   cur_div_nxt = cfg_div;
               cnt_nxt = '0;
               if (en) begin
                  state_nxt   = RUN;
                  clk_out_nxt = 1'b1;
                  tick_nxt    = 1'b1;
               end else begin
                  state_nxt   = IDLE;
                  clk_out_nxt = 1'b0;
               end
            end else begin
               cnt_nxt     = cnt_inc;
               clk_out_nxt = (cnt_inc < (cur_div >> 1));
               if (state == RUN && accept && legal) begin
                  pend_div_nxt = cfg_div;
                  state_nxt    = PEND;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_freq_div_ctrl.sv
// Directed bench for freq_div_ctrl: period/duty measurement, handshake, error, stop and reset cases.
module tb_freq_div_ctrl;

   localparam int CNT_W = 8;

   logic             clk_in = 1'b0;
   logic             reset;
   logic             en;
   logic             cfg_valid;
   logic [CNT_W-1:0] cfg_div;
   logic             cfg_ready, cfg_err, clk_out, tick, busy;

   int checks = 0;
   int errors = 0;

   freq_div_ctrl #(.CNT_W(CNT_W), .DEFAULT_DIV(64)) dut (
      .clk_in   (clk_in),
      .reset    (reset),
      .en       (en),
      .cfg_valid(cfg_valid),
      .cfg_div  (cfg_div),
      .cfg_ready(cfg_ready),
      .cfg_err  (cfg_err),
      .clk_out  (clk_out),
      .tick     (tick),
      .busy     (busy)
   );

   always #5 clk_in = ~clk_in;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic wait_tick(input string tag);
      int n = 0;
      while (!tick && n < 300) begin
         step();
         n++;
      end
      check(tag, int'(tick), 1);
   endtask

   // Starts on a tick sample; ends on the next tick sample.
   task automatic measure(output int per, output int hi);
      per = 0;
      hi  = 0;
      do begin
         if (clk_out) hi++;
         per++;
         step();
      end while (!tick && per < 300);
   endtask

   task automatic offer(input int div);
      cfg_valid = 1'b1;
      cfg_div   = CNT_W'(div);
      step();
      cfg_valid = 1'b0;
   endtask

   initial begin
      int per, hi, n, tk;
      reset     = 1'b0;
      en        = 1'b0;
      cfg_valid = 1'b0;
      cfg_div   = '0;
      #2;
      check("rst_clk_out", int'(clk_out), 0);
      check("rst_tick", int'(tick), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_ready", int'(cfg_ready), 1);
      check("rst_err", int'(cfg_err), 0);

      // 1: default ratio 64
      step();
      reset = 1'b1;
      en    = 1'b1;
      step();
      check("t1_first_tick", int'(tick), 1);
      check("t1_busy", int'(busy), 1);
      measure(per, hi);
      check("t1_period", per, 64);
      check("t1_high", hi, 32);
      measure(per, hi);
      check("t1_period2", per, 64);

      // 2: load 5 while idle, then start
      en = 1'b0;
      n  = 0;
      while (busy && n < 200) begin
         step();
         n++;
      end
      check("t2_stop_cycles", n, 64);
      check("t2_idle_clk", int'(clk_out), 0);
      offer(5);
      check("t2_still_idle", int'(busy), 0);
      check("t2_no_tick", int'(tick), 0);
      en = 1'b1;
      step();
      check("t2_tick_latency", int'(tick), 1);
      measure(per, hi);
      check("t2_period", per, 5);
      check("t2_high", hi, 2);

      // 3: switch to 4, then offer 6 mid-period
      offer(4);
      check("t3_ready_pend", int'(cfg_ready), 0);
      wait_tick("t3_wrap5");
      measure(per, hi);
      check("t3_period4", per, 4);
      check("t3_high4", hi, 2);
      step();
      offer(6);
      check("t3_ready_low", int'(cfg_ready), 0);
      n = 2;
      while (!tick && n < 50) begin
         step();
         n++;
      end
      check("t3_old_period", n, 4);
      check("t3_ready_back", int'(cfg_ready), 1);
      measure(per, hi);
      check("t3_period6", per, 6);
      check("t3_high6", hi, 3);

      // 4: illegal ratios
      offer(1);
      check("t4_err1", int'(cfg_err), 1);
      check("t4_ready1", int'(cfg_ready), 1);
      step();
      check("t4_err1_clr", int'(cfg_err), 0);
      offer(0);
      check("t4_err0", int'(cfg_err), 1);
      step();
      check("t4_err0_clr", int'(cfg_err), 0);
      wait_tick("t4_wrap");
      measure(per, hi);
      check("t4_period", per, 6);
      check("t4_high", hi, 3);

      // 5: N=8, drop en at cnt=2
      offer(8);
      wait_tick("t5_wrap6");
      step();
      step();
      en = 1'b0;
      n  = 0;
      hi = 0;
      tk = 0;
      while (busy && n < 50) begin
         if (clk_out) hi++;
         if (tick) tk++;
         step();
         n++;
      end
      check("t5_remaining", n, 6);
      check("t5_high_rem", hi, 2);
      check("t5_no_tick", tk, 0);
      check("t5_clk_low", int'(clk_out), 0);
      tk = 0;
      for (int i = 0; i < 10; i++) begin
         if (tick || clk_out) tk++;
         step();
      end
      check("t5_quiet", tk, 0);

      // 6: reset while PEND
      en = 1'b1;
      step();
      check("t6_start", int'(tick), 1);
      offer(3);
      step();
      step();
      check("t6_pend", int'(cfg_ready), 0);
      check("t6_clk_hi", int'(clk_out), 1);
      reset = 1'b0;
      #1;
      check("t6_rst_clk", int'(clk_out), 0);
      check("t6_rst_busy", int'(busy), 0);
      check("t6_rst_tick", int'(tick), 0);
      check("t6_rst_ready", int'(cfg_ready), 1);
      step();
      step();
      reset = 1'b1;
      wait_tick("t6_restart");
      measure(per, hi);
      check("t6_period", per, 64);
      check("t6_high", hi, 32);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
